// File: rtl/l2_line_responder_if.sv
// Request/response bundle between the instruction-cache miss path (master)
// and the next-level line responder (slave).
interface l2_line_responder_if;
   logic        req_valid;
   logic [25:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic [25:0] rsp_addr;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_addr
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_last, rsp_addr
   );
endinterface

// File: rtl/l2_line_responder.sv
// Line-fill responder: queues line addresses and returns each as a 16-beat
// burst of synthetic words (word = own byte address) after LATENCY wait cycles.
module l2_line_responder #(
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   l2_line_responder_if.slave   bus,
   output logic [31:0]          fills,
   output logic                 busy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [7:0] WAIT_INIT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t           state;
   logic [25:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [7:0]       wait_cnt;
   logic [3:0]       beat;
   logic [25:0]      cur_addr;
   logic             rsp_valid_q;
   logic             push;
   logic             pop;

   // Full blocks requests even when a pop happens in the same cycle.
   assign bus.req_ready = (count != CNT_W'(FIFO_DEPTH));
   assign push          = bus.req_valid && bus.req_ready;
   assign pop           = (state == IDLE) && (count != '0);

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_last  = rsp_valid_q && (beat == 4'hF);
   assign bus.rsp_data  = rsp_valid_q ? {cur_addr, beat, 2'b00} : 32'h0;
   assign bus.rsp_addr  = (state != IDLE) ? cur_addr : 26'h0;
   assign busy          = (state != IDLE) || (count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.req_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         wait_cnt    <= '0;
         beat        <= '0;
         cur_addr    <= '0;
         rsp_valid_q <= 1'b0;
         fills       <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         case (state)
            IDLE: begin
               if (pop) begin
                  cur_addr <= mem[rd_ptr];
                  wait_cnt <= WAIT_INIT;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == 8'd0) begin
                  beat        <= '0;
                  rsp_valid_q <= 1'b1;
                  state       <= BURST;
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end
            BURST: begin
               // The beat-15 handshake ends the burst, so beat never wraps.
               if (bus.rsp_ready) begin
                  if (beat == 4'hF) begin
                     rsp_valid_q <= 1'b0;
                     fills       <= fills + 32'd1;
                     state       <= IDLE;
                  end else begin
                     beat <= beat + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
